adc_capture_sequencer: RTL and testbench
========================================

// Module: adc_capture_sequencer
// PURPOSE
//   Sequences multi-sample ADC capture on the SPI clock domain. Per frame it drives the ADC chip-select,
//   gates the SIPO shift window (data_logging) and issues one RAM write per sample at an incrementing address.
//   Replaces fixed-address single-sample logging with a DEPTH-sample buffer fill, one-shot or continuous (ring).
//   Sits between the SPI clock generator and the SIPO/RAM datapath; start/abort come from debounced buttons.
// PARAMETERS
//   DATA_W         10  sample width; length of the data_logging window per frame
//   ADDR_W          4  RAM address width
//   DEPTH          16  samples per capture; 1..2**ADDR_W
//   CS_LOW_CYCLES  16  clk cycles cs is low per frame; >= LOG_START+DATA_W
//   CS_HIGH_CYCLES  4  clk cycles cs is high between frames; >= 2
//   LOG_START       3  frame cycle index at which data_logging first asserts
// PORTS
//   clk           in   1         SPI clock; all logic on rising edge
//   reset_b       in   1         asynchronous, active-low reset
//   start         in   1         begin capture; sampled in IDLE or DONE only
//   abort         in   1         terminate capture; priority over start
//   continuous    in   1         1 = ring mode (wrap, never DONE); sampled at each write cycle
//   cs            out  1         ADC chip-select, active low
//   data_logging  out  1         SIPO shift enable
//   ram_we        out  1         one-cycle RAM write strobe
//   ram_addr      out  ADDR_W    RAM write address
//   sample_count  out  ADDR_W+1  samples written this capture; saturates at DEPTH
//   busy          out  1         capture in progress
//   done          out  1         one-shot capture complete (level)
// BEHAVIOUR
//   Reset (async): state IDLE; cs=1, data_logging=0, ram_we=0, ram_addr=0, sample_count=0, busy=0, done=0.
//   All outputs registered. bit_cnt counts 0..CS_LOW_CYCLES-1 in CONVERT; gap_cnt counts cs-high cycles.
//   States: IDLE, CONVERT, WRITE, GAP, DONE.
//   IDLE/DONE + start=1 (abort=0) at edge: -> CONVERT; cs=0, bit_cnt=0, ram_addr=0, sample_count=0, busy=1, done=0.
//   CONVERT: cs=0; data_logging=1 exactly while bit_cnt in [LOG_START, LOG_START+DATA_W-1] (DATA_W cycles).
//     At bit_cnt=CS_LOW_CYCLES-1 -> WRITE.
//   WRITE (1 cycle): cs=1, ram_we=1, ram_addr = current sample slot. On leaving: sample_count+1 (saturate at DEPTH).
//     -> GAP. WRITE counts as first cs-high cycle.
//   GAP: cs=1 for CS_HIGH_CYCLES-1 further cycles, then:
//     slot was DEPTH-1 and continuous=0 (as sampled in WRITE) -> DONE (busy=0, done=1).
//     slot was DEPTH-1 and continuous=1 -> CONVERT, ram_addr=0 (wrap).
//     otherwise -> CONVERT, ram_addr+1.
//   Frame period = CS_LOW_CYCLES + CS_HIGH_CYCLES; one-shot capture = DEPTH frames, cs high CS_HIGH_CYCLES before DONE.
//   DONE: done=1 held until start (restart) or abort; cs=1.
//   start while busy: ignored. start and abort same edge: abort wins.
//   abort=1 at any edge: -> IDLE; cs=1, data_logging=0, ram_we=0, busy=0, done=0. sample_count, ram_addr hold.
//     abort during WRITE cycle: that write completes (ram_we already asserted); no further writes.
//   Async reset mid-frame: immediate return to reset values; no spurious ram_we.
//   DEPTH=1: one frame, single write at addr 0, then DONE (or rewrite addr 0 each frame if continuous).
// TESTING
//   Reset: hold reset_b=0 mid-CONVERT -> cs=1, data_logging=0, ram_we=0, busy=0, done=0, ram_addr=0 immediately.
//   One-shot DEPTH=4, defaults: start pulse -> cs low 16/high 4 per frame x4; data_logging high frame cycles 3..12;
//     ram_we at addr 0,1,2,3 spaced 20 cycles; done=1, busy=0, sample_count=4 after 80 cycles.
//   start held during capture -> no restart; start in DONE -> new capture, ram_addr=0, sample_count=0, done=0.
//   abort at bit_cnt=7 of frame 2 -> next edge cs=1, data_logging=0, busy=0; no ram_we; sample_count=1 held.
//   continuous=1, DEPTH=4 -> writes addr 0,1,2,3,0,1...; done stays 0; sample_count saturates at 4.
//   start and abort same cycle in IDLE -> stays IDLE, busy=0, cs=1.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// Multi-sample ADC capture sequencer on the SPI clock: frames chip-select, gates the SIPO
// shift window and writes one RAM word per frame into a DEPTH-deep buffer (one-shot or ring).
module adc_capture_sequencer #(
  parameter int DATA_W         = 10,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int CS_LOW_CYCLES  = 16,
  parameter int CS_HIGH_CYCLES = 4,
  parameter int LOG_START      = 3
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  output logic              cs,
  output logic              data_logging,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W:0]   sample_count,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_WRITE   = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int BIT_W = $clog2(CS_LOW_CYCLES);
  localparam int GAP_W = $clog2(CS_HIGH_CYCLES);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CS_LOW_CYCLES - 1);
  localparam logic [BIT_W-1:0]  LOG_FIRST = BIT_W'(LOG_START);
  localparam logic [BIT_W-1:0]  LOG_LAST  = BIT_W'(LOG_START + DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_HIGH_CYCLES - 2);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t             state, state_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               cont_q, cont_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [ADDR_W:0]    count_n;
  logic               cs_n, dl_n, we_n, busy_n, done_n;

  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    cont_n    = cont_q;
    addr_n    = ram_addr;
    count_n   = sample_count;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n   = S_CONVERT;
          bit_cnt_n = '0;
          addr_n    = '0;
          count_n   = '0;
        end
      end
      S_CONVERT: begin
        if (bit_cnt == BIT_LAST) begin
          state_n = S_WRITE;
        end else begin
          bit_cnt_n = bit_cnt + BIT_W'(1);
        end
      end
      S_WRITE: begin
        // The ring/one-shot decision is frozen here so a late toggle cannot split a frame.
        state_n   = S_GAP;
        gap_cnt_n = '0;
        cont_n    = continuous;
        if (sample_count != DEPTH_CNT) begin
          count_n = sample_count + (ADDR_W + 1)'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (ram_addr == LAST_SLOT) begin
            if (cont_q) begin
              state_n   = S_CONVERT;
              bit_cnt_n = '0;
              addr_n    = '0;
            end else begin
              state_n = S_DONE;
            end
          end else begin
            state_n   = S_CONVERT;
            bit_cnt_n = '0;
            addr_n    = ram_addr + ADDR_W'(1);
          end
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Abort returns to idle but leaves the address and count showing how far the capture got.
    if (abort) begin
      state_n   = S_IDLE;
      bit_cnt_n = bit_cnt;
      gap_cnt_n = gap_cnt;
      cont_n    = cont_q;
      addr_n    = ram_addr;
      count_n   = sample_count;
    end
  end

  always_comb begin
    cs_n   = (state_n != S_CONVERT);
    dl_n   = (state_n == S_CONVERT) && (bit_cnt_n >= LOG_FIRST) && (bit_cnt_n <= LOG_LAST);
    we_n   = (state_n == S_WRITE);
    busy_n = (state_n == S_CONVERT) || (state_n == S_WRITE) || (state_n == S_GAP);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      cont_q       <= 1'b0;
      cs           <= 1'b1;
      data_logging <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      sample_count <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      gap_cnt      <= gap_cnt_n;
      cont_q       <= cont_n;
      cs           <= cs_n;
      data_logging <= dl_n;
      ram_we       <= we_n;
      ram_addr     <= addr_n;
      sample_count <= count_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer (DEPTH=4, default frame timing).
module tb_adc_capture_sequencer;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       start, abort, continuous;
  logic       cs, data_logging, ram_we, busy, done;
  logic [3:0] ram_addr;
  logic [4:0] sample_count;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  adc_capture_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .continuous(continuous),
    .cs(cs), .data_logging(data_logging), .ram_we(ram_we), .ram_addr(ram_addr),
    .sample_count(sample_count), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Packed view: {cs, data_logging, ram_we, ram_addr[3:0], sample_count[4:0], busy, done}
  localparam logic [13:0] IDLE_V  = {1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
  localparam logic [13:0] CONV0_V = {1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0};

  function automatic logic [13:0] outs();
    return {cs, data_logging, ram_we, ram_addr, sample_count, busy, done};
  endfunction

  // Expected outputs t edges after the start edge, from frame arithmetic (20-cycle frames).
  function automatic logic [13:0] exp_at(int t, bit cont);
    int f, p, cnt;
    if (!cont && t >= 80) return {1'b1, 1'b0, 1'b0, 4'd3, 5'd4, 1'b0, 1'b1};
    f = t / 20;
    p = t % 20;
    cnt = f + ((p >= 17) ? 1 : 0);
    if (cnt > 4) cnt = 4;
    return {1'(p >= 16), 1'(p >= 3 && p <= 12), 1'(p == 16), 4'(f % 4), 5'(cnt), 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input int idx, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    checks++;
    if (state_dbg !== exp) begin
      errors++;
      $display("FAIL %s: state_dbg got %0d expected %0d", name, state_dbg, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        abort;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{start: 1'b1, abort: 1'b1, exp: IDLE_V};
    vecs[1] = '{start: 1'b0, abort: 1'b1, exp: IDLE_V};
    vecs[2] = '{start: 1'b0, abort: 1'b0, exp: IDLE_V};
    vecs[3] = '{start: 1'b1, abort: 1'b0, exp: CONV0_V};
    vecs[4] = '{start: 1'b0, abort: 1'b1, exp: IDLE_V};
    vecs[5] = '{start: 1'b1, abort: 1'b1, exp: IDLE_V};

    reset_b = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", 0, outs(), IDLE_V);
    check_state("reset_state", 3'd0);
    reset_b = 1'b1;

    // Table: start/abort interplay from IDLE, one edge per record
    for (int i = 0; i < 6; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      @(negedge clk);
      check("vec", i, outs(), vecs[i].exp);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // One-shot capture, start held for the first 40 cycles (must not restart)
    start = 1'b1;
    for (int t = 0; t <= 90; t++) begin
      @(negedge clk);
      check("oneshot", t, outs(), exp_at(t, 1'b0));
      if (t == 40) start = 1'b0;
    end
    check_state("done_state", 3'd4);

    // Restart from DONE, then abort at bit_cnt=7 of frame 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart", 0, outs(), exp_at(0, 1'b0));
    for (int t = 1; t <= 27; t++) begin
      @(negedge clk);
      check("restart", t, outs(), exp_at(t, 1'b0));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort", 0, outs(), {1'b1, 1'b0, 1'b0, 4'd1, 5'd1, 1'b0, 1'b0});
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      check("abort_hold", t, outs(), {1'b1, 1'b0, 1'b0, 4'd1, 5'd1, 1'b0, 1'b0});
    end
    check_state("abort_state", 3'd0);

    // Continuous ring capture over 6+ frames
    continuous = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ring", 0, outs(), exp_at(0, 1'b1));
    for (int t = 1; t <= 129; t++) begin
      @(negedge clk);
      check("ring", t, outs(), exp_at(t, 1'b1));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    continuous = 1'b0;
    check("ring_abort", 0, outs(), {1'b1, 1'b0, 1'b0, 4'd2, 5'd4, 1'b0, 1'b0});

    // Asynchronous reset in the middle of frame 2 (logging window open)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 25; t++) @(negedge clk);
    check("pre_reset", 25, outs(), exp_at(25, 1'b0));
    #2;
    reset_b = 1'b0;
    #1;
    check("async_reset", 0, outs(), IDLE_V);
    @(negedge clk);
    check("reset_held", 0, outs(), IDLE_V);
    reset_b = 1'b1;
    @(negedge clk);
    check("after_reset", 0, outs(), IDLE_V);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
